// File: rtl/apb_pkg.sv
// Shared APB definitions: arbiter state encoding and the select-width helper
// also used by apb_fastdecode.
package apb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_t;

  // Bits needed to index n items; a single item still gets one bit.
  function automatic int SELBITS(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first requester found scanning upward
// from i_rr, wrapping modulo PORTS.
module apb_rr_pick
  import apb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int SELW  = SELBITS(PORTS)
) (
  input  logic [PORTS-1:0] i_req,
  input  logic [SELW-1:0]  i_rr,
  output logic [SELW-1:0]  o_idx,
  output logic             o_valid
);

  // Scan from the lowest priority back to i_rr so the last hit is the winner.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      int j;
      logic [SELW-1:0] w_cand;
      j = int'(i_rr) + k;
      if (j >= PORTS) j = j - PORTS;
      w_cand = SELW'(j);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one downstream APB bus among PORTS masters.
// Define APB_ARB_TIMEOUT_EN to add a watchdog that error-terminates stalled ACCESS phases.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int PORTS          = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PORTS*32-1:0] s_paddr,
  input  logic [PORTS-1:0]    s_pwrite,
  input  logic [PORTS-1:0]    s_psel,
  input  logic [PORTS-1:0]    s_penable,
  input  logic [PORTS*32-1:0] s_pwdata,
  output logic [PORTS*32-1:0] s_prdata,
  output logic [PORTS-1:0]    s_pready,
  output logic [PORTS-1:0]    s_pslverr,
  output logic [31:0]         m_paddr,
  output logic                m_pwrite,
  output logic                m_psel,
  output logic                m_penable,
  output logic [31:0]         m_pwdata,
  input  logic [31:0]         m_prdata,
  input  logic                m_pready,
  input  logic                m_pslverr
);

  localparam int SELW = SELBITS(PORTS);

  arb_state_t      r_state;
  arb_state_t      w_next;
  logic [SELW-1:0] r_gnt;
  logic [SELW-1:0] r_rr;
  logic [SELW-1:0] w_pick;
  logic            w_pickValid;
  logic [PORTS-1:0] w_req;
  logic            w_timeout;
  logic            w_done;
  logic [31:0]     w_addrArr  [PORTS];
  logic [31:0]     w_wdataArr [PORTS];

  // Only access-phase cycles count as requests; setup-only cycles are ignored.
  assign w_req = s_psel & s_penable;

  apb_rr_pick #(.PORTS(PORTS), .SELW(SELW)) u_pick (
    .i_req  (w_req),
    .i_rr   (r_rr),
    .o_idx  (w_pick),
    .o_valid(w_pickValid)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TCW-1:0] r_tcnt;

  assign w_timeout = (r_state == ARB_ACCESS) && !m_pready &&
                     (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if (w_next == ARB_SETUP) begin
      r_tcnt <= '0;
    end else if ((r_state == ARB_ACCESS) && !m_pready) begin
      r_tcnt <= r_tcnt + TCW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = (r_state == ARB_ACCESS) && (m_pready || w_timeout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:   if (w_pickValid) w_next = ARB_SETUP;
      ARB_SETUP:  w_next = ARB_ACCESS;
      ARB_ACCESS: if (w_done) w_next = ARB_IDLE;
      default:    w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ARB_IDLE) && w_pickValid) begin
        r_gnt <= w_pick;
        r_rr  <= (w_pick == SELW'(PORTS - 1)) ? '0 : w_pick + SELW'(1);
      end
    end
  end

  for (genvar g = 0; g < PORTS; g++) begin : g_unpack
    assign w_addrArr[g]  = s_paddr[g*32 +: 32];
    assign w_wdataArr[g] = s_pwdata[g*32 +: 32];
  end

  assign m_psel    = (r_state != ARB_IDLE);
  assign m_penable = (r_state == ARB_ACCESS);
  assign m_paddr   = w_addrArr[r_gnt];
  assign m_pwrite  = s_pwrite[r_gnt];
  assign m_pwdata  = w_wdataArr[r_gnt];

  // A forced termination reports an error and hides whatever the stalled slave drives.
  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = {PORTS{m_prdata}};
    if (w_done) begin
      s_pready[r_gnt]  = 1'b1;
      s_pslverr[r_gnt] = m_pslverr | w_timeout;
    end
    for (int g = 0; g < PORTS; g++) begin
      if (w_timeout && (r_gnt == SELW'(g))) s_prdata[g*32 +: 32] = '0;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model. Define APB_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_apb_arbiter;

  localparam int P  = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [P*32-1:0] s_paddr = '0;
  logic [P*32-1:0] s_pwdata = '0;
  logic [P-1:0]    s_pwrite = '0;
  logic [P-1:0]    s_psel = '0;
  logic [P-1:0]    s_penable = '0;
  logic [P*32-1:0] s_prdata;
  logic [P-1:0]    s_pready;
  logic [P-1:0]    s_pslverr;
  logic [31:0]     m_paddr;
  logic [31:0]     m_pwdata;
  logic [31:0]     m_prdata = '0;
  logic            m_pwrite;
  logic            m_psel;
  logic            m_penable;
  logic            m_pready = 1'b0;
  logic            m_pslverr = 1'b0;

  int vecCount = 0;
  int missCount = 0;
  bit modelOn = 1'b0;
  int mBusy = 0, mAge = 0, mStall = 0, mOwner = 0, mRr = 0;
  int served [8];
  int nServed = 0;
  int agent [P];
  logic [P-1:0] saw;

  apb_arbiter #(.PORTS(P), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwdata(s_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic sel, input logic en,
                               input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    s_psel[i]             = sel;
    s_penable[i]          = en;
    s_paddr[i*32 +: 32]   = addr;
    s_pwrite[i]           = wr;
    s_pwdata[i*32 +: 32]  = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve every master currently requesting; record completion order.
  task automatic drain(input int budget);
    logic [P-1:0] done;
    nServed = 0;
    for (int i = 0; i < 8; i++) served[i] = -1;
    for (int c = 0; c < budget && s_psel != '0; c++) begin
      @(negedge clk);
      done = s_pready;
      for (int i = 0; i < P; i++) begin
        if (done[i] && nServed < 8) begin
          served[nServed] = i;
          nServed++;
        end
      end
      tick();
      for (int i = 0; i < P; i++) begin
        if (done[i]) begin
          s_psel[i]    = 1'b0;
          s_penable[i] = 1'b0;
        end
      end
    end
    checkOutput("drain_all_served", 32'(s_psel), 32'd0);
  endtask

  // Transaction-level reference: one transfer owns the bus from grant until its response.
  always @(negedge clk) begin : model
    logic expPen, respond, tmo;
    logic [P-1:0] expReady, expErr;
    int pick;
    if (modelOn) begin
      expPen  = (mBusy != 0) && (mAge >= 1);
      respond = expPen && m_pready;
      tmo     = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo = expPen && !m_pready && (mStall + 1 == TO);
`endif
      expReady = '0;
      expErr   = '0;
      if (respond || tmo) begin
        expReady[mOwner] = 1'b1;
        expErr[mOwner]   = m_pslverr || tmo;
      end
      checkOutput("m_psel", 32'(m_psel), 32'(mBusy != 0));
      checkOutput("m_penable", 32'(m_penable), 32'(expPen));
      checkOutput("s_pready", 32'(s_pready), 32'(expReady));
      checkOutput("s_pslverr", 32'(s_pslverr), 32'(expErr));
      if (mBusy != 0) begin
        checkOutput("m_paddr", m_paddr, s_paddr[mOwner*32 +: 32]);
        checkOutput("m_pwrite", 32'(m_pwrite), 32'(s_pwrite[mOwner]));
        checkOutput("m_pwdata", m_pwdata, s_pwdata[mOwner*32 +: 32]);
      end
      for (int i = 0; i < P; i++) begin
        checkOutput("s_prdata", s_prdata[i*32 +: 32], (tmo && i == mOwner) ? 32'd0 : m_prdata);
      end

      if (reset) begin
        mBusy = 0; mAge = 0; mStall = 0; mOwner = 0; mRr = 0;
      end else if (mBusy != 0) begin
        if (respond || tmo) begin
          mBusy = 0;
        end else begin
          if (expPen) mStall++;
          mAge++;
        end
      end else begin
        pick = -1;
        for (int k = 0; k < P; k++) begin
          if (pick < 0 && s_psel[(mRr + k) % P] && s_penable[(mRr + k) % P]) pick = (mRr + k) % P;
        end
        if (pick >= 0) begin
          mOwner = pick; mRr = (pick + 1) % P; mBusy = 1; mAge = 0; mStall = 0;
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    modelOn = 1'b1;
    @(negedge clk);
    checkOutput("rst_m_psel", 32'(m_psel), 32'd0);
    checkOutput("rst_m_penable", 32'(m_penable), 32'd0);
    checkOutput("rst_s_pready", 32'(s_pready), 32'd0);
    checkOutput("rst_s_pslverr", 32'(s_pslverr), 32'd0);
    tick();
    reset = 1'b0;

    // Single zero-wait read by master 0.
    m_pready = 1'b1; m_prdata = 32'hDEAD_BEEF; m_pslverr = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0404, 1'b0, 32'd0);
    @(negedge clk); checkOutput("t1_setup_only", 32'(m_psel), 32'd0);
    tick(); s_penable[0] = 1'b1;
    @(negedge clk); checkOutput("t1_c0_psel", 32'(m_psel), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t1_c1_psel", 32'(m_psel), 32'd1);
    checkOutput("t1_c1_penable", 32'(m_penable), 32'd0);
    checkOutput("t1_c1_paddr", m_paddr, 32'h0000_0404);
    tick();
    @(negedge clk);
    checkOutput("t1_c2_penable", 32'(m_penable), 32'd1);
    checkOutput("t1_c2_pready", 32'(s_pready), 32'd1);
    checkOutput("t1_c2_prdata", s_prdata[31:0], 32'hDEAD_BEEF);
    tick(); s_psel[0] = 1'b0; s_penable[0] = 1'b0;
    @(negedge clk); checkOutput("t1_c3_psel", 32'(m_psel), 32'd0);

    // Simultaneous pairs after reset: order 0 then 1, three times.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int rep = 0; rep < 3; rep++) begin
      applyStimulus(0, 1'b1, 1'b0, 32'h100 + rep, 1'b0, 32'd0);
      applyStimulus(1, 1'b1, 1'b0, 32'h200 + rep, 1'b1, 32'hA5A5_0000 + rep);
      tick(); s_penable = '1;
      drain(40);
      checkOutput("t2_count", 32'(nServed), 32'd2);
      checkOutput("t2_first", 32'(served[0]), 32'd0);
      checkOutput("t2_second", 32'(served[1]), 32'd1);
    end

    // Master 1 write with 3 wait states; master 0 arrives mid-transfer.
    m_pready = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0808, 1'b1, 32'h1234_5678);
    tick(); s_penable[1] = 1'b1;
    tick(); applyStimulus(0, 1'b1, 1'b0, 32'h0000_0C0C, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("t3_setup_penable", 32'(m_penable), 32'd0);
    checkOutput("t3_setup_pwrite", 32'(m_pwrite), 32'd1);
    checkOutput("t3_setup_pwdata", m_pwdata, 32'h1234_5678);
    checkOutput("t3_setup_paddr", m_paddr, 32'h0000_0808);
    tick(); s_penable[0] = 1'b1;
    @(negedge clk); checkOutput("t3_wait1_pready", 32'(s_pready), 32'd0);
    tick(); tick();
    @(negedge clk); checkOutput("t3_wait3_pready", 32'(s_pready), 32'd0);
    tick(); m_pready = 1'b1;
    @(negedge clk); checkOutput("t3_done1_pready", 32'(s_pready), 32'd2);
    tick(); s_psel[1] = 1'b0; s_penable[1] = 1'b0;
    @(negedge clk);
    checkOutput("t3_gap_psel", 32'(m_psel), 32'd0);
    checkOutput("t3_gap_pready", 32'(s_pready), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("t3_m0_setup_psel", 32'(m_psel), 32'd1);
    checkOutput("t3_m0_setup_penable", 32'(m_penable), 32'd0);
    checkOutput("t3_m0_setup_paddr", m_paddr, 32'h0000_0C0C);
    tick();
    @(negedge clk); checkOutput("t3_m0_pready", 32'(s_pready), 32'd1);
    tick(); s_psel[0] = 1'b0; s_penable[0] = 1'b0;

    // Slave error is routed only to the granted master.
    m_pslverr = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0900, 1'b0, 32'd0);
    tick(); s_penable[1] = 1'b1;
    tick(); tick();
    @(negedge clk);
    checkOutput("t4_pready", 32'(s_pready), 32'd2);
    checkOutput("t4_pslverr", 32'(s_pslverr), 32'd2);
    tick(); s_psel[1] = 1'b0; s_penable[1] = 1'b0; m_pslverr = 1'b0;

    // Reset during ACCESS abandons the transfer and restarts priority at master 0.
    m_pready = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0500, 1'b0, 32'd0);
    tick(); s_penable[0] = 1'b1;
    tick(); applyStimulus(1, 1'b1, 1'b0, 32'h0000_0600, 1'b0, 32'd0);
    tick(); s_penable[1] = 1'b1; reset = 1'b1;
    @(negedge clk); checkOutput("t5_access", 32'(m_penable), 32'd1);
    tick(); reset = 1'b0;
    @(negedge clk); checkOutput("t5_psel_drop", 32'(m_psel), 32'd0);
    tick(); m_pready = 1'b1;
    @(negedge clk);
    checkOutput("t5_regrant_psel", 32'(m_psel), 32'd1);
    checkOutput("t5_regrant_addr", m_paddr, 32'h0000_0500);
    drain(40);
    checkOutput("t5_first", 32'(served[0]), 32'd0);
    checkOutput("t5_second", 32'(served[1]), 32'd1);

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never ready: forced error response on the TO-th ACCESS cycle.
    m_pready = 1'b0; m_prdata = 32'hCAFE_F00D;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'd0);
    tick(); s_penable[0] = 1'b1;
    tick();
    for (int k = 1; k <= TO; k++) begin
      tick();
      @(negedge clk);
      if (k < TO) begin
        checkOutput("to_wait_pready", 32'(s_pready), 32'd0);
      end else begin
        checkOutput("to_pready", 32'(s_pready), 32'd1);
        checkOutput("to_pslverr", 32'(s_pslverr), 32'd1);
        checkOutput("to_prdata", s_prdata[31:0], 32'd0);
      end
    end
    tick(); s_psel[0] = 1'b0; s_penable[0] = 1'b0;
    @(negedge clk); checkOutput("to_idle_psel", 32'(m_psel), 32'd0);
`endif

    // Random traffic: APB-behaved masters, random slave, occasional reset.
    for (int i = 0; i < P; i++) agent[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      saw = s_pready;
      tick();
      reset     = ($urandom_range(0, 249) == 0);
      m_pready  = ($urandom_range(0, 9) < 6);
      m_pslverr = ($urandom_range(0, 4) == 0);
      m_prdata  = $urandom;
      for (int i = 0; i < P; i++) begin
        if (agent[i] == 2 && saw[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            applyStimulus(i, 1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom);
            agent[i] = 1;
          end else begin
            s_psel[i] = 1'b0; s_penable[i] = 1'b0;
            agent[i] = 0;
          end
        end else if (agent[i] == 1) begin
          s_penable[i] = 1'b1;
          agent[i] = 2;
        end else if (agent[i] == 0 && $urandom_range(0, 2) == 0) begin
          applyStimulus(i, 1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom);
          agent[i] = 1;
        end
      end
    end
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Multi-master APB arbiter that shares one APB bus, typically feeding `apb_fastdecode`, between PORTS requesting masters such as a CPU bridge, DMA and debug port. Masters present normal APB transfers. The arbiter grants one at a time with round-robin priority, re-issues the transfer downstream with its own SETUP/ACCESS phases, and stalls the other masters with `pready` low. An optional watchdog terminates transfers the downstream slave never completes.

## Interface
- PORTS, 2, number of upstream masters (2..8).
- TIMEOUT_CYCLES, 16, number of ACCESS cycles with `m_pready` low before forced termination. Used only with `APB_ARB_TIMEOUT_EN`.
- Clock is `clk` and reset is `reset`. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_paddr`  in  PORTS*32  per-master address; master i occupies bits [i*32 +: 32].
- `s_pwrite`  in  PORTS  per-master write.
- `s_psel`  in  PORTS  per-master select.
- `s_penable`  in  PORTS  per-master enable.
- `s_pwdata`  in  PORTS*32  per-master write data.
- `s_prdata`  out  PORTS*32  read data, `m_prdata` broadcast to every slot.
- `s_pready`  out  PORTS  ready, only ever asserted to the granted master.
- `s_pslverr`  out  PORTS  error, only ever asserted to the granted master.
- `m_paddr`  out  32  downstream address.
- `m_pwrite`  out  1  downstream write.
- `m_psel`  out  1  downstream select.
- `m_penable`  out  1  downstream enable.
- `m_pwdata`  out  32  downstream write data.
- `m_prdata`  in  32  downstream read data.
- `m_pready`  in  1  downstream ready.
- `m_pslverr`  in  1  downstream error.

## Operation
- Request: master i is requesting when `s_psel[i] & s_penable[i]` (its access phase). Setup-phase-only cycles are ignored.
- State machine has three states:
  - IDLE: if any request is present, register grant index `gnt` = winner → SETUP. Otherwise stay in IDLE.
  - SETUP: `m_psel`=1, `m_penable`=0 → ACCESS unconditionally.
  - ACCESS: `m_psel`=1, `m_penable`=1. When `m_pready`=1: `s_pready[gnt]`=1, `s_pslverr[gnt]`=`m_pslverr`, then → IDLE. Otherwise stay in ACCESS.
- Round-robin:
  - Pointer `rr` holds the highest-priority index. Search runs rr, rr+1, …, wrapping modulo PORTS.
  - On each grant, `rr` ← gnt+1 (wrapping PORTS-1 → 0).
  - After reset, `rr`=0.
- Datapath: `m_paddr`/`m_pwrite`/`m_pwdata` are a combinational mux of master `gnt`. They are valid in SETUP and ACCESS and are don't-care in IDLE.
- Ungranted masters see `s_pready`=0 and `s_pslverr`=0 and hold their transfer per APB rules.
- A master that drops `s_psel` while granted violates protocol; the arbiter does not detect this.
- ACCESS → IDLE always. A one-cycle IDLE gap between transfers guarantees the just-completed master's request is re-sampled with fresh penable.
- Reset mid-transfer: the next edge forces IDLE, `m_psel`=0, `m_penable`=0, `rr`=0, `gnt`=0. The interrupted master's transfer is abandoned.

## Timing
- Reset values: `m_psel`=0, `m_penable`=0, `s_pready`=0, `s_pslverr`=0, state IDLE, timeout counter 0.
- Uncontended latency, with request first seen in cycle 0 (IDLE):
  - cycle 1: SETUP.
  - cycle 2: ACCESS. With zero-wait slave, `s_pready` is asserted in cycle 2, i.e. 2 wait states added.
  - Each downstream wait state adds one cycle.
- Throughput: one transfer per 3 cycles minimum.
- Simultaneous requests are resolved strictly by `rr`. A new request arriving during SETUP/ACCESS waits for IDLE.
- `s_pready`/`s_pslverr` are combinational from `m_pready`/`m_pslverr` and registered state.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES)+1 counts ACCESS cycles with `m_pready`=0 and clears on entering SETUP.
  - In the TIMEOUT_CYCLES-th such cycle the arbiter asserts `s_pready[gnt]`=1 and `s_pslverr[gnt]`=1, forces `s_prdata` slot `gnt` to 0, and goes to IDLE, dropping `m_psel`.
  - If `m_pready` rises in that same cycle, the real response wins.
- `APB_ARB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely and TIMEOUT_CYCLES is ignored.

## Structure
- Shared package `apb_pkg` holds:
  - state encoding constants `ARB_IDLE`=2'd0, `ARB_SETUP`=2'd1, `ARB_ACCESS`=2'd2;
  - the SELBITS width function shared with `apb_fastdecode`.
- Sub-module `apb_rr_pick`: combinational round-robin winner. Inputs are the request vector and `rr`; outputs are the index and a valid flag.

## Test plan
- Single master 0 reads 0x0000_0404 with zero-wait slave returning 0xDEAD_BEEF → `m_psel` rises cycle 1, `m_penable` cycle 2; `s_pready[0]`=1 with `s_prdata[31:0]`=0xDEAD_BEEF in cycle 2.
- Masters 0 and 1 request in the same cycle after reset → master 0 is served first, master 1 next. Repeat both requests → master 0 then 1 again; a third simultaneous pair is served in order 0,1 with `rr` alternating.
- Master 1 writes 0x1234_5678 while the slave inserts 3 wait states and master 0 requests mid-transfer → `s_pready[0]` stays 0 until master 1 completes; master 0 gets SETUP 2 cycles after master 1's `s_pready`.
- Slave returns `m_pslverr`=1 → only `s_pslverr[gnt]`=1, in the same cycle as `s_pready[gnt]`.
- Reset asserted during ACCESS → `m_psel`=0 next cycle; following grant goes to master 0.
- With `APB_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, slave never ready → `s_pready`=`s_pslverr`=1 and prdata 0 on the 16th ACCESS cycle, then IDLE.
